// File: rtl/ysyx_ifu_if.sv
// ============================================================================
// Module  : ysyx_ifu_if
// Brief   : Fetch-unit bundle: imem request/response, decoder and commit ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ysyx_ifu_if #(
  parameter int unsigned CNT_W = 32
);
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [31:0]      imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             imem_rsp_err;
  logic             inst_valid;
  logic             inst_ready;
  logic [31:0]      inst;
  logic [31:0]      pc;
  logic             commit;
  logic [31:0]      next_pc;
  logic             fetch_err;
  logic [CNT_W-1:0] inst_cnt;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, pc, fetch_err, inst_cnt,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           inst_ready, commit, next_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, pc, fetch_err, inst_cnt,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           inst_ready, commit, next_pc
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_ifu.sv
// ============================================================================
// Module  : ysyx_ifu
// Brief   : Multi-cycle instruction fetch unit, one instruction in flight.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  ysyx_ifu_if.master ifu_bus
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_EXEC  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_BOOT:  state_d = S_REQ;
      S_REQ:   if (ifu_bus.imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (ifu_bus.imem_rsp_valid) begin
          if (ifu_bus.imem_rsp_err) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            inst_d  = ifu_bus.imem_rsp_data;
            state_d = S_VALID;
          end
        end
      end
      S_VALID: if (ifu_bus.inst_ready) state_d = S_EXEC;
      S_EXEC: begin
        if (ifu_bus.commit) begin
          // A misaligned target halts without retiring the current instruction.
          if (ifu_bus.next_pc[1:0] == 2'b00) begin
            pc_d    = ifu_bus.next_pc;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_REQ;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_BOOT;
    endcase
  end

  assign ifu_bus.imem_req_valid = (state_q == S_REQ);
  assign ifu_bus.imem_req_addr  = pc_q;
  assign ifu_bus.inst_valid     = (state_q == S_VALID);
  assign ifu_bus.inst           = inst_q;
  assign ifu_bus.pc             = pc_q;
  assign ifu_bus.fetch_err      = err_q;
  assign ifu_bus.inst_cnt       = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_ifu.sv
// ============================================================================
// Module  : tb_ysyx_ifu
// Brief   : Directed self-checking bench for ysyx_ifu with a reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   acc_cnt  = 0;
  logic cmp_en   = 1'b0;

  always #5 clk = ~clk;

  ysyx_ifu_if #(.CNT_W(32)) bus ();

  ysyx_ifu #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .ifu_bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch loop as a sequence of phases.
  // 0 boot, 1 fetch request, 2 awaiting word, 3 offered to decoder, 4 executing, 5 halted
  int          m_phase;
  logic [31:0] m_pc, m_inst, m_cnt;
  logic        m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_pc <= RST_PC; m_inst <= 32'h0; m_cnt <= 32'h0; m_err <= 1'b0;
    end else begin
      if (m_phase == 0) m_phase <= 1;
      else if (m_phase == 1 && bus.imem_req_ready) m_phase <= 2;
      else if (m_phase == 2 && bus.imem_rsp_valid) begin
        if (bus.imem_rsp_err) begin m_err <= 1'b1; m_phase <= 5; end
        else begin m_inst <= bus.imem_rsp_data; m_phase <= 3; end
      end
      else if (m_phase == 3 && bus.inst_ready) m_phase <= 4;
      else if (m_phase == 4 && bus.commit) begin
        if (bus.next_pc % 4 == 0) begin
          m_pc <= bus.next_pc; m_cnt <= m_cnt + 1; m_phase <= 1;
        end else begin
          m_err <= 1'b1; m_phase <= 5;
        end
      end
    end
  end

  always @(posedge clk)
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) acc_cnt <= acc_cnt + 1;

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("model_req_valid", {31'b0, bus.imem_req_valid}, {31'b0, m_phase == 1});
      chk("model_req_addr",  bus.imem_req_addr, m_pc);
      chk("model_inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_phase == 3});
      chk("model_inst", bus.inst, m_inst);
      chk("model_pc",   bus.pc, m_pc);
      chk("model_err",  {31'b0, bus.fetch_err}, {31'b0, m_err});
      chk("model_cnt",  bus.inst_cnt, m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req_valid && n < 20) begin step(); n++; end
    if (!bus.imem_req_valid) chk("wait_req_timeout", 32'h0, 32'h1);
  endtask

  // Request accepted immediately, word returned one cycle later.
  task automatic do_fetch(input logic [31:0] data, input logic err);
    wait_req();
    step();
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = data; bus.imem_rsp_err = err;
    step();
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_err = 1'b0;
  endtask

  task automatic present_commit(input logic [31:0] npc);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0; bus.commit = 1'b1; bus.next_pc = npc;
    step();
    bus.commit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int acc0;
    bus.imem_req_ready = 1'b1; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus.imem_rsp_err = 1'b0; bus.inst_ready = 1'b0; bus.commit = 1'b0; bus.next_pc = 32'h0;
    step(); step();
    chk("reset_pc", bus.pc, RST_PC);
    chk("reset_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("reset_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // BOOT lasts one cycle, then the first request at the reset PC
    step();
    chk("first_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    chk("first_req_addr", bus.imem_req_addr, 32'h8000_0000);
    do_fetch(32'h0000_0413, 1'b0);
    chk("first_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    chk("first_inst", bus.inst, 32'h0000_0413);
    chk("first_pc", bus.pc, 32'h8000_0000);
    present_commit(32'h8000_0004);
    chk("seq_addr", bus.imem_req_addr, 32'h8000_0004);
    chk("seq_cnt", bus.inst_cnt, 32'd1);

    do_fetch(32'h0010_0093, 1'b0);
    present_commit(32'h8000_0100);
    chk("jump_addr", bus.imem_req_addr, 32'h8000_0100);
    chk("jump_cnt", bus.inst_cnt, 32'd2);

    // Memory stalls the request for three cycles
    bus.imem_req_ready = 1'b0;
    acc0 = acc_cnt;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
      chk("stall_req_addr", bus.imem_req_addr, 32'h8000_0100);
    end
    bus.imem_req_ready = 1'b1;
    step();
    chk("stall_one_accept", acc_cnt - acc0, 32'd1);
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0020_0113;
    step();
    bus.imem_rsp_valid = 1'b0;

    // Decoder stalls; a commit inside the window must not retire anything
    for (int i = 0; i < 5; i++) begin
      bus.commit = (i == 2); bus.next_pc = 32'h8000_0200;
      step();
      chk("dec_stall_inst", bus.inst, 32'h0020_0113);
      chk("dec_stall_pc", bus.pc, 32'h8000_0100);
      chk("dec_stall_cnt", bus.inst_cnt, 32'd2);
    end
    bus.commit = 1'b0;
    present_commit(32'h8000_0104);
    chk("after_stall_cnt", bus.inst_cnt, 32'd3);

    // Bus error on the response halts the unit for good
    do_fetch(32'hFFFF_FFFF, 1'b1);
    acc0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.commit = 1'b1; bus.next_pc = 32'h8000_0300;
      step();
      chk("rsp_err_sticky", {31'b0, bus.fetch_err}, 32'h1);
      chk("rsp_err_no_req", {31'b0, bus.imem_req_valid}, 32'h0);
    end
    bus.commit = 1'b0;
    chk("rsp_err_no_accept", acc_cnt - acc0, 32'd0);
    chk("rsp_err_cnt", bus.inst_cnt, 32'd3);

    // Misaligned next PC
    do_reset();
    do_fetch(32'h0000_0013, 1'b0);
    present_commit(32'h8000_0002);
    chk("misalign_err", {31'b0, bus.fetch_err}, 32'h1);
    chk("misalign_pc", bus.pc, 32'h8000_0000);
    chk("misalign_cnt", bus.inst_cnt, 32'd0);

    // Reset while awaiting a response, then a stray response afterwards
    do_reset();
    do_fetch(32'h0000_0013, 1'b0);
    present_commit(32'h8000_0004);
    wait_req();
    step();
    rst = 1'b1;
    #1;
    chk("async_rst_pc", bus.pc, RST_PC);
    chk("async_rst_cnt", bus.inst_cnt, 32'd0);
    chk("async_rst_inst", bus.inst, 32'h0);
    step();
    rst = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
    step(); step();
    chk("stray_rsp_ignored", bus.inst, 32'h0);
    bus.imem_rsp_valid = 1'b0; bus.imem_req_ready = 1'b1;
    chk("restart_addr", bus.imem_req_addr, 32'h8000_0000);
    do_fetch(32'h0000_0297, 1'b0);
    chk("restart_inst", bus.inst, 32'h0000_0297);
    chk("restart_cnt", bus.inst_cnt, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
